// File: rtl/mul_arbiter_seq.sv
// Two-requester round-robin front end for a shift-and-add multiplier (one bit of A per cycle).
// Optional build macro MUL_ARBITER_EARLY_EXIT_EN: finish as soon as the remaining A bits are zero.
module mul_arbiter_seq #(
    parameter int AW = 3,
    parameter int BW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [AW-1:0]      a0,
    input  logic [AW-1:0]      a1,
    input  logic [BW-1:0]      b0,
    input  logic [BW-1:0]      b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [AW+BW-1:0]   p
);

    localparam int PW = AW + BW;
    localparam int CW = (AW > 1) ? $clog2(AW) : 1;
    localparam logic [CW-1:0] LAST = CW'(AW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // A is consumed LSB-first by shifting right; B is pre-widened and shifted left to track B << k.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [PW-1:0] b;
        logic          id;
    } op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] p_q, p_d;
    logic          done_id_q, done_id_d;
    logic          last_q, last_d;
    logic [1:0]    gnt_q, gnt_d;

    logic          win;
    logic [PW-1:0] sum;
    logic          fin;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        done_id_d = done_id_q;
        last_d    = last_q;
        gnt_d     = 2'b00;
        win       = 1'b0;
        sum       = acc_q + (op_q.a[0] ? op_q.b : '0);
`ifdef MUL_ARBITER_EARLY_EXIT_EN
        fin       = (cnt_q == LAST) || ((op_q.a >> 1) == '0);
`else
        fin       = (cnt_q == LAST);
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // With both asking, the one that did not win last time goes first.
                    win      = (req0 && req1) ? ~last_q : req1;
                    op_d.a   = win ? a1 : a0;
                    op_d.b   = PW'(win ? b1 : b0);
                    op_d.id  = win;
                    last_d   = win;
                    acc_d    = '0;
                    cnt_d    = '0;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d  = sum;
                op_d.a = op_q.a >> 1;
                op_d.b = op_q.b << 1;
                cnt_d  = cnt_q + 1'b1;
                if (fin) begin
                    p_d       = sum;
                    done_id_d = op_q.id;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            p_q       <= '0;
            done_id_q <= 1'b0;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            done_id_q <= done_id_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
        end
    end

    assign gnt0    = gnt_q[0];
    assign gnt1    = gnt_q[1];
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign p       = p_q;

endmodule

// File: tb/tb_mul_arbiter_seq.sv
// Directed bench for mul_arbiter_seq (AW=3, BW=4); inputs driven and outputs sampled on the falling edge.
module tb_mul_arbiter_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [2:0] a0, a1;
    logic [3:0] b0, b1;
    logic       gnt0, gnt1, busy, done, done_id;
    logic [6:0] p;

    int n_checks = 0;
    int n_fail   = 0;

    mul_arbiter_seq #(.AW(3), .BW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .done_id(done_id), .p(p)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input int a);
`ifdef MUL_ARBITER_EARLY_EXIT_EN
        if (a >= 4) return 3;
        if (a >= 2) return 2;
        return 1;
`else
        return 3;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one request (caller at a falling edge, DUT idle) and reports what came back.
    task automatic do_op(input bit id, input logic [2:0] a, input logic [3:0] b,
                         output logic g0, output logic g1, output int lat,
                         output logic [6:0] pv, output logic idv, output logic dn2);
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        tick();
        g0 = gnt0; g1 = gnt1;
        req0 = 1'b0; req1 = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
        pv = p; idv = done_id;
        tick();
        dn2 = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({gnt0, gnt1, busy, done, done_id} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {gnt0, gnt1, busy, done, done_id});
        end
        n_checks++;
        if (p !== 7'd0) begin n_fail++; $display("FAIL reset_p: got %0d expected 0", p); end
    endtask

    task automatic test_basic();
        logic g0, g1, pid, dn2; int lat; logic [6:0] pv;
        rst_n = 1'b1;   // request presented on the very first edge out of reset
        do_op(1'b0, 3'd5, 4'd11, g0, g1, lat, pv, pid, dn2);
        n_checks++;
        if ({g0, g1} !== 2'b10) begin n_fail++; $display("FAIL basic_gnt: got %b expected 10", {g0, g1}); end
        n_checks++;
        if (lat !== exp_lat(5)) begin n_fail++; $display("FAIL basic_lat: got %0d expected %0d", lat, exp_lat(5)); end
        n_checks++;
        if (pv !== 7'd55 || pid !== 1'b0) begin
            n_fail++; $display("FAIL basic_p: got p=%0d id=%0d expected p=55 id=0", pv, pid);
        end
        n_checks++;
        if (dn2 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %0d expected 0", dn2); end
    endtask

    task automatic test_roundrobin();
        int lat;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req0 = 1'b1; a0 = 3'd3; b0 = 4'd2;
        req1 = 1'b1; a1 = 3'd7; b1 = 4'd15;
        tick();
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL rr_first_gnt: got %b expected 10", {gnt0, gnt1}); end
        req0 = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin tick(); lat++; end
        n_checks++;
        if (!done || p !== 7'd6 || done_id !== 1'b0) begin
            n_fail++; $display("FAIL rr_first_p: got done=%0d p=%0d id=%0d expected done=1 p=6 id=0", done, p, done_id);
        end
        tick();
        n_checks++;
        if ({gnt0, gnt1, busy} !== 3'b000) begin n_fail++; $display("FAIL rr_idle: got %b expected 000", {gnt0, gnt1, busy}); end
        tick();
        n_checks++;
        if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL rr_second_gnt: got %b expected 01", {gnt0, gnt1}); end
        req1 = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin tick(); lat++; end
        n_checks++;
        if (lat !== exp_lat(7) || p !== 7'd105 || done_id !== 1'b1) begin
            n_fail++; $display("FAIL rr_second_p: got lat=%0d p=%0d id=%0d expected lat=%0d p=105 id=1", lat, p, done_id, exp_lat(7));
        end
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        n_checks++;
        if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL rr_third_gnt: got %b expected 10", {gnt0, gnt1}); end
        req0 = 1'b0; req1 = 1'b0;
        lat = 0;
        while (!done && lat < 10) begin tick(); lat++; end
        n_checks++;
        if (p !== 7'd6 || done_id !== 1'b0) begin
            n_fail++; $display("FAIL rr_third_p: got p=%0d id=%0d expected p=6 id=0", p, done_id);
        end
        tick();
    endtask

    task automatic test_ignore();
        int g1cnt = 0, dcnt = 0;
        logic [6:0] pv = '0;
        req0 = 1'b1; a0 = 3'd5; b0 = 4'd11;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) req0 = 1'b0;
            if (c == 1) begin req1 = 1'b1; a1 = 3'd2; b1 = 4'd3; end
            if (c == 2) req1 = 1'b0;
            if (gnt1) g1cnt++;
            if (done) begin dcnt++; pv = p; end
        end
        n_checks++;
        if (g1cnt !== 0) begin n_fail++; $display("FAIL ignore_gnt1: got %0d expected 0", g1cnt); end
        n_checks++;
        if (dcnt !== 1 || pv !== 7'd55) begin
            n_fail++; $display("FAIL ignore_done: got dones=%0d p=%0d expected dones=1 p=55", dcnt, pv);
        end
    endtask

    task automatic test_mid_reset();
        logic g0, g1, pid, dn2; int lat; logic [6:0] pv; int dcnt = 0;
        req0 = 1'b1; a0 = 3'd5; b0 = 4'd11;
        tick();
        req0 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({gnt0, gnt1, busy, done, done_id} !== 5'b0 || p !== 7'd0) begin
            n_fail++; $display("FAIL midrst_state: got ctl=%b p=%0d expected ctl=00000 p=0", {gnt0, gnt1, busy, done, done_id}, p);
        end
        rst_n = 1'b1;
        repeat (5) begin tick(); if (done) dcnt++; end
        n_checks++;
        if (dcnt !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", dcnt); end
        do_op(1'b0, 3'd6, 4'd7, g0, g1, lat, pv, pid, dn2);
        n_checks++;
        if (lat !== exp_lat(6) || pv !== 7'd42 || pid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_fresh: got lat=%0d p=%0d id=%0d expected lat=%0d p=42 id=0", lat, pv, pid, exp_lat(6));
        end
    endtask

    task automatic test_one();
        logic g0, g1, pid, dn2; int lat; logic [6:0] pv;
        do_op(1'b0, 3'd1, 4'd9, g0, g1, lat, pv, pid, dn2);
        n_checks++;
        if (lat !== exp_lat(1)) begin n_fail++; $display("FAIL one_lat: got %0d expected %0d", lat, exp_lat(1)); end
        n_checks++;
        if (pv !== 7'd9 || dn2 !== 1'b0) begin
            n_fail++; $display("FAIL one_p: got p=%0d done_after=%0d expected p=9 done_after=0", pv, dn2);
        end
    endtask

    task automatic test_sweep();
        logic g0, g1, pid, dn2; int lat; logic [6:0] pv;
        int a, b;
        for (int i = 0; i < 128; i++) begin
            a = i / 16; b = i % 16;
            do_op(i[0], 3'(a), 4'(b), g0, g1, lat, pv, pid, dn2);
            n_checks++;
            if (int'(pv) !== a * b || pid !== i[0]) begin
                n_fail++; $display("FAIL sweep_p a=%0d b=%0d: got p=%0d id=%0d expected p=%0d id=%0d", a, b, pv, pid, a * b, i[0]);
            end
            n_checks++;
            if (lat !== exp_lat(a) || {g1, g0} !== (i[0] ? 2'b10 : 2'b01) || dn2 !== 1'b0) begin
                n_fail++; $display("FAIL sweep_ctl a=%0d b=%0d: got lat=%0d gnt10=%b dn2=%0d expected lat=%0d one gnt dn2=0",
                                   a, b, lat, {g1, g0}, dn2, exp_lat(a));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_roundrobin();
        test_ignore();
        test_mid_reset();
        test_one();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_arbiter_seq.md
MUL_ARBITER_SEQ -- requirements
Module: mul_arbiter_seq

Interface
REQ-001 SHALL provide parameter AW, default 3, the multiplicand A width.
REQ-002 SHALL provide parameter BW, default 4, the multiplier B width; product width PW = AW+BW.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL provide port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL provide ports req0/req1, input, 1, the requester 0/1 operation request.
REQ-006 SHALL provide ports a0/a1, input, AW, the requester 0/1 operand A.
REQ-007 SHALL provide ports b0/b1, input, BW, the requester 0/1 operand B.
REQ-008 SHALL provide ports gnt0/gnt1, output, 1, the one-cycle acceptance pulse to requester 0/1.
REQ-009 SHALL provide port busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL provide port done, output, 1, the one-cycle result-valid pulse.
REQ-011 SHALL provide port done_id, output, 1, the requester index owning the result on done.
REQ-012 SHALL provide port p, output, PW, the registered product.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on accept; RUN->DONE on last bit; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL sample req0/req1 only in IDLE; requests in RUN/DONE are ignored (not queued).
REQ-015 SHALL accept at the IDLE edge with any req high: latch the winner's a/b, set cur_id, clear accumulator and bit counter, enter RUN, and pulse the matching gnt for exactly the following cycle.
REQ-016 SHALL grant a lone request directly; with both req high, SHALL grant the requester not equal to last_id, then set last_id to the winner (round-robin).
REQ-017 SHALL, at each RUN edge for bit k (k = 0..AW-1), add (B << k), zero-extended to PW bits, into the PW-bit accumulator when A[k]=1; no overflow is possible (max (2^AW-1)(2^BW-1) fits PW).
REQ-018 SHALL, without early exit, stay in RUN for exactly AW cycles, so done rises AW cycles after gnt rises (3 for defaults).
REQ-019 SHALL, at the edge entering DONE, load p with the final accumulator and done_id with cur_id; done is high for the one DONE cycle only.
REQ-020 SHALL hold p and done_id stable from DONE until the next DONE entry.
REQ-021 SHALL pulse at most one gnt per accepted operation; gnt0 and gnt1 are never high together.
REQ-022 SHALL require the requester to hold req and operands until gnt and to drop req in the gnt cycle; a req still high in the next IDLE cycle is a new request.
REQ-023 SHALL produce p = A*B exactly for all operand values, including A=0 or B=0 (p=0).

Reset
REQ-024 SHALL, at any edge with rst_n=0, including mid-RUN, force state IDLE, clear accumulator, counter and p to 0, drive gnt0, gnt1, busy, done and done_id to 0, set last_id to 1, and discard the in-flight operation with no done.
REQ-025 SHALL accept a request on the first edge after rst_n returns high.

Configuration
REQ-026 SHALL support macro MUL_ARBITER_EARLY_EXIT_EN: when defined, at each RUN edge, if the unprocessed A bits above k are all zero, the FSM enters DONE on that edge, minimum 1 RUN cycle (done 1 cycle after gnt when A<=1); when undefined, RUN always lasts AW cycles; p is identical in both builds.

Verification
REQ-027 SHALL cover: reset, then req0=1, a0=5, b0=11 -> gnt0 next cycle, done 3 cycles after gnt0, p=55, done_id=0.
REQ-028 SHALL cover: req0 and req1 both high after reset, a0=3,b0=2, a1=7,b1=15 -> requester 0 served first (p=6), then requester 1 (p=105, done_id=1); next simultaneous request grants requester 0.
REQ-029 SHALL cover: req1 pulsed during RUN of requester 0 and dropped before IDLE -> no gnt1, no second done.
REQ-030 SHALL cover: rst_n=0 in the second RUN cycle -> busy=0, p=0 next cycle, no done; fresh request afterwards completes correctly.
REQ-031 SHALL cover: a0=1,b0=9 -> p=9; with MUL_ARBITER_EARLY_EXIT_EN done 1 cycle after gnt0, without it 3 cycles.
REQ-032 SHALL cover: exhaustive sweep of all 128 (a,b) pairs on alternating requesters -> every p equals a*b with correct done_id.
